// File: rtl/cfu_pkg.sv
// Shared types for the Cfu command path: field widths and the packed command payload.
package cfu_pkg;

    localparam int unsigned FUNC_ID_W = 10;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned CMD_W     = FUNC_ID_W + 2 * DATA_W;

    typedef struct packed {
        logic [FUNC_ID_W-1:0] function_id;
        logic [DATA_W-1:0]    inputs_0;
        logic [DATA_W-1:0]    inputs_1;
    } cfu_cmd_t;

endpackage

// File: rtl/cfu_cmd_fifo_mem.sv
// Command storage for cfu_cmd_fifo: DEPTH x cfu_cmd_t registers,
// one synchronous write port and one asynchronous read port, no reset.
module cfu_cmd_fifo_mem
    import cfu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  cfu_cmd_t       wdata,
    input  logic [AW-1:0]  raddr,
    output cfu_cmd_t       rdata
);

    cfu_cmd_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/cfu_cmd_fifo.sv
// Command queue in front of the Cfu: decouples CPU issue from Cfu back-pressure.
// Define CFU_CMD_FIFO_BYPASS_EN for zero-latency pass-through when the queue is empty.
module cfu_cmd_fifo
    import cfu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_cmd_valid,
    output logic                 in_cmd_ready,
    input  logic [FUNC_ID_W-1:0] in_cmd_payload_function_id,
    input  logic [DATA_W-1:0]    in_cmd_payload_inputs_0,
    input  logic [DATA_W-1:0]    in_cmd_payload_inputs_1,
    output logic                 out_cmd_valid,
    input  logic                 out_cmd_ready,
    output logic [FUNC_ID_W-1:0] out_cmd_payload_function_id,
    output logic [DATA_W-1:0]    out_cmd_payload_inputs_0,
    output logic [DATA_W-1:0]    out_cmd_payload_inputs_1,
    output logic [AW:0]          level,
    output logic [AW:0]          high_water
);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] level_q, level_d;
    logic [AW:0] high_water_q, high_water_d;

    logic     empty, full;
    logic     push, pop;
    logic     wr_en, rd_en;
    logic     pass;
    cfu_cmd_t in_cmd, head_cmd, out_cmd;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign in_cmd = {in_cmd_payload_function_id, in_cmd_payload_inputs_0, in_cmd_payload_inputs_1};

    // Ready depends only on registered state, so a pop cannot free a slot in the same cycle.
    assign in_cmd_ready = reset && !full;
    assign push         = in_cmd_valid && in_cmd_ready;
    assign pop          = out_cmd_valid && out_cmd_ready;

`ifdef CFU_CMD_FIFO_BYPASS_EN
    assign out_cmd_valid = !empty || (in_cmd_valid && in_cmd_ready);
    assign out_cmd       = empty ? in_cmd : head_cmd;
    assign pass          = empty && push && out_cmd_ready;
`else
    assign out_cmd_valid = !empty;
    assign out_cmd       = head_cmd;
    assign pass          = 1'b0;
`endif

    // A passed-through command is neither stored nor counted.
    assign wr_en = push && !pass && !flush;
    assign rd_en = pop && !empty && !flush;

    assign out_cmd_payload_function_id = out_cmd.function_id;
    assign out_cmd_payload_inputs_0    = out_cmd.inputs_0;
    assign out_cmd_payload_inputs_1    = out_cmd.inputs_1;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        high_water_d = high_water_q;
        if (flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            level_d      = '0;
            high_water_d = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end
            if (wr_en && !rd_en) begin
                level_d = level_q + (AW+1)'(1);
            end else if (rd_en && !wr_en) begin
                level_d = level_q - (AW+1)'(1);
            end
            if (level_d > high_water_q) begin
                high_water_d = level_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            high_water_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            high_water_q <= high_water_d;
        end
    end

    assign level      = level_q;
    assign high_water = high_water_q;

    cfu_cmd_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (in_cmd),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (head_cmd)
    );

endmodule

// File: tb/tb_cfu_cmd_fifo.sv
// Directed bench for cfu_cmd_fifo: stimulus queues expected commands, a monitor checks every Cfu-side handshake.
module tb_cfu_cmd_fifo;
    import cfu_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 flush;
    logic                 in_cmd_valid;
    logic                 in_cmd_ready;
    logic [FUNC_ID_W-1:0] in_fid;
    logic [DATA_W-1:0]    in_d0, in_d1;
    logic                 out_cmd_valid;
    logic                 out_cmd_ready;
    logic [FUNC_ID_W-1:0] out_fid;
    logic [DATA_W-1:0]    out_d0, out_d1;
    logic [AW:0]          level;
    logic [AW:0]          high_water;

    int n_cmp = 0;
    int n_err = 0;
    cfu_cmd_t exp_q[$];

    always #5 clk = ~clk;

    cfu_cmd_fifo #(.DEPTH(DEPTH)) dut (
        .clk                         (clk),
        .reset                       (reset),
        .flush                       (flush),
        .in_cmd_valid                (in_cmd_valid),
        .in_cmd_ready                (in_cmd_ready),
        .in_cmd_payload_function_id  (in_fid),
        .in_cmd_payload_inputs_0     (in_d0),
        .in_cmd_payload_inputs_1     (in_d1),
        .out_cmd_valid               (out_cmd_valid),
        .out_cmd_ready               (out_cmd_ready),
        .out_cmd_payload_function_id (out_fid),
        .out_cmd_payload_inputs_0    (out_d0),
        .out_cmd_payload_inputs_1    (out_d1),
        .level                       (level),
        .high_water                  (high_water)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive the CPU-side payload and record the command as expected downstream.
    task automatic drive_cmd(input logic [9:0] fid, input bit expect_out);
        cfu_cmd_t c;
        c.function_id = fid;
        c.inputs_0    = {22'h0, fid} * 32'h0101_0101;
        c.inputs_1    = ~c.inputs_0;
        in_cmd_valid  = 1'b1;
        in_fid        = c.function_id;
        in_d0         = c.inputs_0;
        in_d1         = c.inputs_1;
        if (expect_out) exp_q.push_back(c);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every accepted Cfu-side command must match the queue head.
    always @(negedge clk) begin
        if (reset && out_cmd_valid && out_cmd_ready && !flush) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_cmd", 32'(out_fid), 32'h3ff_ffff);
            end else begin
                cfu_cmd_t e;
                e = exp_q.pop_front();
                chk("out_function_id", 32'(out_fid), 32'(e.function_id));
                chk("out_inputs_0", out_d0, e.inputs_0);
                chk("out_inputs_1", out_d1, e.inputs_1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; flush = 1'b0; in_cmd_valid = 1'b0; out_cmd_ready = 1'b0;
        in_fid = '0; in_d0 = '0; in_d1 = '0;

        // Reset held low
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_cmd_ready), 32'd0);
        chk("rst_out_valid", 32'(out_cmd_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_cmd_ready), 32'd1);
        chk("idle_out_valid", 32'(out_cmd_valid), 32'd0);
        chk("idle_level", 32'(level), 32'd0);
        chk("idle_high_water", 32'(high_water), 32'd0);

        // Fill with Cfu stalled
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            drive_cmd(10'(i), 1'b1);
            if (i == 1) begin
                @(negedge clk);
                chk("first_in_d0", in_d0, 32'h0101_0101);
            end
        end
        next_cycle();
        in_cmd_valid = 1'b0;
        @(negedge clk);
        chk("full_in_ready", 32'(in_cmd_ready), 32'd0);
        chk("full_level", 32'(level), 32'd4);
        chk("full_high_water", 32'(high_water), 32'd4);
        chk("full_head_fid", 32'(out_fid), 32'h001);

        // Drain in order
        next_cycle();
        out_cmd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("drain_level", 32'(level), 32'(4 - k));
            next_cycle();
        end
        out_cmd_ready = 1'b0;
        @(negedge clk);
        chk("drained_level", 32'(level), 32'd0);
        chk("drained_out_valid", 32'(out_cmd_valid), 32'd0);
        chk("drained_high_water", 32'(high_water), 32'd4);

        // Steady stream
        next_cycle();
        out_cmd_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_cmd(10'(12'h100 + i), 1'b1);
            @(negedge clk);
`ifdef CFU_CMD_FIFO_BYPASS_EN
            chk("stream_level", 32'(level), 32'd0);
`else
            chk("stream_level", 32'(level), (i == 0) ? 32'd0 : 32'd1);
`endif
            next_cycle();
        end
        in_cmd_valid = 1'b0;
        next_cycle();
        out_cmd_ready = 1'b0;
        @(negedge clk);
        chk("stream_done_level", 32'(level), 32'd0);
        chk("stream_all_out", 32'(exp_q.size()), 32'd0);

        // Full plus pop: ready stays low, push lands one cycle later
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            drive_cmd(10'(12'h200 + i), 1'b1);
        end
        next_cycle();
        drive_cmd(10'h205, 1'b1);
        out_cmd_ready = 1'b1;
        @(negedge clk);
        chk("fullpop_in_ready", 32'(in_cmd_ready), 32'd0);
        chk("fullpop_level", 32'(level), 32'd4);
        next_cycle();
        out_cmd_ready = 1'b0;
        @(negedge clk);
        chk("fullpop_after_level", 32'(level), 32'd3);
        chk("fullpop_after_ready", 32'(in_cmd_ready), 32'd1);
        next_cycle();
        in_cmd_valid = 1'b0;
        @(negedge clk);
        chk("fullpop_refill_level", 32'(level), 32'd4);
        next_cycle();
        out_cmd_ready = 1'b1;
        repeat (4) next_cycle();
        out_cmd_ready = 1'b0;
        @(negedge clk);
        chk("fullpop_drained", 32'(exp_q.size()), 32'd0);

        // Flush with simultaneous push and pop
        for (int i = 1; i <= 3; i++) begin
            next_cycle();
            drive_cmd(10'(12'h300 + i), 1'b1);
        end
        next_cycle();
        drive_cmd(10'h3ff, 1'b0);
        out_cmd_ready = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk("preflush_level", 32'(level), 32'd3);
        next_cycle();
        flush = 1'b0;
        in_cmd_valid = 1'b0;
        out_cmd_ready = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_high_water", 32'(high_water), 32'd0);
        chk("flush_out_valid", 32'(out_cmd_valid), 32'd0);
        next_cycle();
        drive_cmd(10'h3a0, 1'b1);
        next_cycle();
        in_cmd_valid = 1'b0;
        @(negedge clk);
        chk("postflush_level", 32'(level), 32'd1);
        chk("postflush_high_water", 32'(high_water), 32'd1);
        next_cycle();
        out_cmd_ready = 1'b1;
        next_cycle();
        out_cmd_ready = 1'b0;
        @(negedge clk);
        chk("postflush_drained", 32'(exp_q.size()), 32'd0);

`ifdef CFU_CMD_FIFO_BYPASS_EN
        // Zero-latency pass-through on empty FIFO
        next_cycle();
        drive_cmd(10'h2a3, 1'b1);
        out_cmd_ready = 1'b1;
        @(negedge clk);
        chk("bypass_out_valid", 32'(out_cmd_valid), 32'd1);
        chk("bypass_fid", 32'(out_fid), 32'h2a3);
        chk("bypass_level_same", 32'(level), 32'd0);
        next_cycle();
        in_cmd_valid = 1'b0;
        out_cmd_ready = 1'b0;
        @(negedge clk);
        chk("bypass_level_after", 32'(level), 32'd0);
        chk("bypass_out_valid_after", 32'(out_cmd_valid), 32'd0);
`endif

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
